// File: rtl/ev_fit_tracker.sv
// rtl/ev_fit_tracker.sv - serial lattice-energy fitness evaluator with best-individual tracker (optional EV_PERIODIC_BOUNDARY_EN)
module ev_fit_tracker #(
    parameter int INT8_LENGTH     = 8,
    parameter int ENERGY_LENGTH   = 4,
    parameter int PARTICLE_LENGTH = 2,
    parameter int LATTICE_LENGTH  = 11,
    parameter int IND_FIT_LENGTH  = 10
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [INT8_LENGTH-1:0]                num_generations,
    input  logic [INT8_LENGTH-1:0]                pop_size,
    input  logic [ENERGY_LENGTH-1:0]              self_energy,
    input  logic [ENERGY_LENGTH-1:0]              interact_energy,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] ind_state_in,
    input  logic [INT8_LENGTH-1:0]                ind_mut_in,
    output logic                                  fit_valid,
    output logic [IND_FIT_LENGTH-1:0]             fit_out,
    output logic [IND_FIT_LENGTH-1:0]             min_fit_out,
    output logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] best_ind_state,
    output logic [INT8_LENGTH-1:0]                best_ind_mut,
    output logic [INT8_LENGTH-1:0]                gen_count,
    output logic                                  done
);
    localparam int SW = PARTICLE_LENGTH * LATTICE_LENGTH;
    localparam int IW = $clog2(LATTICE_LENGTH);
    localparam int XW = IND_FIT_LENGTH + 2;
    localparam logic [XW-1:0] FMAX = {2'b00, {IND_FIT_LENGTH{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ACCEPT, S_EVAL, S_UPDATE, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [INT8_LENGTH-1:0]      gens_q, gens_d, pop_q, pop_d;
    logic [ENERGY_LENGTH-1:0]    self_q, self_d, inter_q, inter_d;
    logic [SW-1:0]               ind_q, ind_d, best_q, best_d;
    logic [INT8_LENGTH-1:0]      mut_q, mut_d, best_mut_q, best_mut_d;
    logic [IW-1:0]               site_q, site_d;
    logic [IND_FIT_LENGTH-1:0]   acc_q, acc_d, fit_q, fit_d, min_q, min_d;
    logic [INT8_LENGTH-1:0]      gen_cnt_q, gen_cnt_d, ind_cnt_q, ind_cnt_d;

    logic [PARTICLE_LENGTH-1:0]  cur_site, prev_site, first_site;
    logic                        add_self, add_int, add_wrap, last_site;
    logic [XW-1:0]               self_x, inter_x, sum;
    logic [IND_FIT_LENGTH-1:0]   acc_next;

    // Select the current and previous lattice site and compute the saturated running energy
    always_comb begin
        cur_site   = '0;
        prev_site  = '0;
        first_site = ind_q[PARTICLE_LENGTH-1:0];
        for (int i = 0; i < LATTICE_LENGTH; i++) begin
            if (site_q == IW'(i)) begin
                cur_site  = ind_q[i*PARTICLE_LENGTH +: PARTICLE_LENGTH];
                prev_site = ind_q[((i == 0) ? 0 : i - 1)*PARTICLE_LENGTH +: PARTICLE_LENGTH];
            end
        end
        last_site = (site_q == IW'(LATTICE_LENGTH - 1));
        add_self  = (cur_site != '0);
        add_int   = (site_q != '0) && (cur_site == prev_site) && (cur_site != '0);
`ifdef EV_PERIODIC_BOUNDARY_EN
        add_wrap  = last_site && (cur_site == first_site) && (cur_site != '0);
`else
        add_wrap  = 1'b0;
`endif
        self_x  = {{(XW-ENERGY_LENGTH){1'b0}}, self_q};
        inter_x = {{(XW-ENERGY_LENGTH){1'b0}}, inter_q};
        sum = {2'b00, acc_q}
            + (add_self ? self_x  : '0)
            + (add_int  ? inter_x : '0)
            + (add_wrap ? inter_x : '0);
        acc_next = (sum > FMAX) ? FMAX[IND_FIT_LENGTH-1:0] : sum[IND_FIT_LENGTH-1:0];
    end

    // Run control: next state plus next values of every tracked register
    always_comb begin
        state_d    = state_q;
        gens_d     = gens_q;
        pop_d      = pop_q;
        self_d     = self_q;
        inter_d    = inter_q;
        ind_d      = ind_q;
        mut_d      = mut_q;
        site_d     = site_q;
        acc_d      = acc_q;
        fit_d      = fit_q;
        min_d      = min_q;
        best_d     = best_q;
        best_mut_d = best_mut_q;
        gen_cnt_d  = gen_cnt_q;
        ind_cnt_d  = ind_cnt_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: begin
                gens_d     = num_generations;
                pop_d      = pop_size;
                self_d     = self_energy;
                inter_d    = interact_energy;
                min_d      = '1;
                best_d     = '0;
                best_mut_d = '0;
                gen_cnt_d  = '0;
                ind_cnt_d  = '0;
                state_d    = (num_generations == '0 || pop_size == '0) ? S_DONE : S_ACCEPT;
            end
            S_ACCEPT: if (in_valid) begin
                ind_d   = ind_state_in;
                mut_d   = ind_mut_in;
                acc_d   = '0;
                site_d  = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                acc_d = acc_next;
                if (last_site) begin
                    fit_d   = acc_next;
                    site_d  = '0;
                    state_d = S_UPDATE;
                end else begin
                    site_d = site_q + IW'(1);
                end
            end
            S_UPDATE: begin
                if (fit_q < min_q) begin
                    min_d      = fit_q;
                    best_d     = ind_q;
                    best_mut_d = mut_q;
                end
                state_d = S_ACCEPT;
                if (ind_cnt_q + INT8_LENGTH'(1) == pop_q) begin
                    ind_cnt_d = '0;
                    gen_cnt_d = gen_cnt_q + INT8_LENGTH'(1);
                    if (gen_cnt_q + INT8_LENGTH'(1) == gens_q) state_d = S_DONE;
                end else begin
                    ind_cnt_d = ind_cnt_q + INT8_LENGTH'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gens_q     <= '0;
            pop_q      <= '0;
            self_q     <= '0;
            inter_q    <= '0;
            ind_q      <= '0;
            mut_q      <= '0;
            site_q     <= '0;
            acc_q      <= '0;
            fit_q      <= '0;
            min_q      <= '0;
            best_q     <= '0;
            best_mut_q <= '0;
            gen_cnt_q  <= '0;
            ind_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gens_q     <= gens_d;
            pop_q      <= pop_d;
            self_q     <= self_d;
            inter_q    <= inter_d;
            ind_q      <= ind_d;
            mut_q      <= mut_d;
            site_q     <= site_d;
            acc_q      <= acc_d;
            fit_q      <= fit_d;
            min_q      <= min_d;
            best_q     <= best_d;
            best_mut_q <= best_mut_d;
            gen_cnt_q  <= gen_cnt_d;
            ind_cnt_q  <= ind_cnt_d;
        end
    end

    assign in_ready       = (state_q == S_ACCEPT);
    assign fit_valid      = (state_q == S_UPDATE);
    assign done           = (state_q == S_DONE);
    assign fit_out        = fit_q;
    assign min_fit_out    = min_q;
    assign best_ind_state = best_q;
    assign best_ind_mut   = best_mut_q;
    assign gen_count      = gen_cnt_q;
endmodule

// File: tb/tb_ev_fit_tracker.sv
// tb/tb_ev_fit_tracker.sv - scoreboard testbench for ev_fit_tracker
module tb_ev_fit_tracker;
`ifdef EV_PERIODIC_BOUNDARY_EN
    localparam int FIT1 = 55;
    localparam int FIT2 = 35;
`else
    localparam int FIT1 = 53;
    localparam int FIT2 = 33;
`endif

    logic        clk = 0, rst_n = 0, start = 0, start2 = 0, in_valid = 0;
    logic [7:0]  num_gen = 0, pop = 0, ind_mut = 0;
    logic [3:0]  self_e = 0, inter_e = 0;
    logic [21:0] ind_state = 0;

    logic        in_ready, fit_valid, done;
    logic [9:0]  fit_out, min_fit;
    logic [21:0] best_state;
    logic [7:0]  best_mut, gen_count;

    logic        in_ready2, fit_valid2, done2;
    logic [5:0]  fit_out2, min_fit2;
    logic [21:0] best_state2;
    logic [7:0]  best_mut2, gen_count2;

    int tests = 0, failed = 0, cyc = 0;
    int fit_cnt = 0, done_cnt = 0, fit_cyc = 0, done_cyc = 0;
    int fit_cnt2 = 0, done_cnt2 = 0;
    bit ready_seen = 0;
    int exp_q[$];
    int exp2_q[$];

    ev_fit_tracker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_generations(num_gen), .pop_size(pop),
        .self_energy(self_e), .interact_energy(inter_e), .in_valid(in_valid), .in_ready(in_ready),
        .ind_state_in(ind_state), .ind_mut_in(ind_mut), .fit_valid(fit_valid), .fit_out(fit_out),
        .min_fit_out(min_fit), .best_ind_state(best_state), .best_ind_mut(best_mut),
        .gen_count(gen_count), .done(done));

    ev_fit_tracker #(.IND_FIT_LENGTH(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_generations(num_gen), .pop_size(pop),
        .self_energy(self_e), .interact_energy(inter_e), .in_valid(in_valid), .in_ready(in_ready2),
        .ind_state_in(ind_state), .ind_mut_in(ind_mut), .fit_valid(fit_valid2), .fit_out(fit_out2),
        .min_fit_out(min_fit2), .best_ind_state(best_state2), .best_ind_mut(best_mut2),
        .gen_count(gen_count2), .done(done2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: pop expected fitness whenever a DUT presents one
    always @(negedge clk) begin
        if (in_ready) ready_seen = 1;
        if (fit_valid) begin
            fit_cnt++;
            fit_cyc = cyc;
            if (exp_q.size() == 0) check("fit_unexpected", fit_out, -1);
            else check("fit_out", fit_out, exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (fit_valid2) begin
            fit_cnt2++;
            if (exp2_q.size() == 0) check("fit2_unexpected", fit_out2, -1);
            else check("fit_out_sat", fit_out2, exp2_q.pop_front());
        end
        if (done2) done_cnt2++;
    end

    task automatic do_start(input bit sel, input int g, input int p, input int s, input int k, output int scyc);
        @(negedge clk);
        num_gen = 8'(g); pop = 8'(p); self_e = 4'(s); inter_e = 4'(k);
        scyc = cyc;
        if (sel) start2 = 1; else start = 1;
        @(negedge clk);
        start = 0; start2 = 0;
    endtask

    task automatic send(input bit sel, input logic [21:0] st, input logic [7:0] mut,
                        input bit push, input int exp, output int acyc);
        int n = 0;
        while (!(sel ? in_ready2 : in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        acyc = cyc;
        if (n >= 100) begin
            check("ready_timeout", 0, 1);
        end else begin
            ind_state = st; ind_mut = mut; in_valid = 1;
            if (push) begin
                if (sel) exp2_q.push_back(exp); else exp_q.push_back(exp);
            end
            @(negedge clk);
            in_valid = 0;
        end
    endtask

    task automatic wait_done(input bit sel);
        int d0 = sel ? done_cnt2 : done_cnt;
        int n = 0;
        while ((sel ? done_cnt2 : done_cnt) == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("done_timeout", 0, 1);
    endtask

    int t, s, f0, d0;
    logic [21:0] gstates [6] = '{22'h005555, 22'h000055, 22'h000099, 22'h000555, 22'h055555, 22'h000155};
    int          gfits   [6] = '{40, 20, 20, 30, 50, 25};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_fit_out", fit_out, 0);
        check("rst_min_fit", min_fit, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        rst_n = 1;

        // all type 1, self=3 interact=2
        do_start(0, 1, 1, 3, 2, s);
        send(0, 22'h155555, 8'h11, 1, FIT1, t);
        wait_done(0);
        check("latency", fit_cyc - t, 12);
        check("done_after_fit", done_cyc - fit_cyc, 1);
        check("min_fit_1", min_fit, FIT1);
        check("best_state_1", best_state, 22'h155555);
        check("best_mut_1", best_mut, 8'h11);
        check("gen_count_1", gen_count, 1);

        // asynchronous reset in the middle of EVAL
        do_start(0, 1, 1, 3, 2, s);
        send(0, 22'h199999, 8'h44, 0, 0, t);
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_fit_out", fit_out, 0);
        check("mid_rst_min_fit", min_fit, 0);
        check("mid_rst_best_state", best_state, 0);
        check("mid_rst_best_mut", best_mut, 0);
        check("mid_rst_gen_count", gen_count, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_fit_valid", fit_valid, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // alternating types 1/2
        do_start(0, 1, 1, 3, 2, s);
        send(0, 22'h199999, 8'h22, 1, FIT2, t);
        wait_done(0);
        check("best_state_alt", best_state, 22'h199999);
        check("min_fit_alt", min_fit, FIT2);

        // two generations of three, tie on 20 keeps the first
        f0 = fit_cnt; d0 = done_cnt;
        do_start(0, 2, 3, 5, 0, s);
        for (int i = 0; i < 6; i++) send(0, gstates[i], 8'(i + 1), 1, gfits[i], t);
        wait_done(0);
        repeat (5) @(negedge clk);
        check("gen_fit_pulses", fit_cnt - f0, 6);
        check("gen_done_pulses", done_cnt - d0, 1);
        check("gen_min_fit", min_fit, 20);
        check("gen_best_mut", best_mut, 2);
        check("gen_best_state", best_state, 22'h000055);
        check("gen_count_2", gen_count, 2);

        // saturation with a 6-bit fitness
        do_start(1, 1, 1, 15, 15, s);
        send(1, 22'h155555, 8'h77, 1, 63, t);
        wait_done(1);
        check("sat_min_fit", min_fit2, 63);
        check("sat_best_mut", best_mut2, 0);
        check("sat_gen_count", gen_count2, 1);

        // pop_size = 0 finishes immediately
        ready_seen = 0;
        do_start(0, 1, 0, 3, 2, s);
        wait_done(0);
        check("zero_done_latency", done_cyc - s, 2);
        check("zero_ready_seen", ready_seen, 0);
        check("zero_min_fit", min_fit, 10'h3FF);
        check("zero_best_state", best_state, 0);
        check("zero_best_mut", best_mut, 0);
        check("zero_gen_count", gen_count, 0);

        // start during EVAL is ignored
        f0 = fit_cnt; d0 = done_cnt;
        do_start(0, 1, 1, 3, 2, s);
        send(0, 22'h155555, 8'h33, 1, FIT1, t);
        repeat (3) @(negedge clk);
        pop = 0; start = 1;
        @(negedge clk);
        start = 0; pop = 1;
        wait_done(0);
        repeat (5) @(negedge clk);
        check("ign_fit_pulses", fit_cnt - f0, 1);
        check("ign_done_pulses", done_cnt - d0, 1);
        check("ign_best_mut", best_mut, 8'h33);
        check("ign_gen_count", gen_count, 1);

        check("queue_empty", exp_q.size() + exp2_q.size(), 0);
        check("sat_fit_pulses", fit_cnt2, 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ev_fit_tracker.md
Name: ev_fit_tracker

Overview:
- Parametrised successor to the evolutionary-search top: serial lattice-energy fitness evaluator plus best-individual tracker, run over a configurable number of generations.
- Accepts one individual per handshake and evaluates it one lattice site per cycle.
- Keeps the minimum-fitness individual and its mutation rate, and pulses done after num_generations × pop_size evaluations.
- Sits between the population/mutation engine (upstream) and result readout (downstream).

Parameters:
INT8_LENGTH, 8, width of counts and mutation rate
ENERGY_LENGTH, 4, width of energy coefficients
PARTICLE_LENGTH, 2, bits per lattice site (type 0 = empty)
LATTICE_LENGTH, 11, sites per individual (≥2)
IND_FIT_LENGTH, 10, fitness width (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  one-cycle pulse; latches config, clears trackers
num_generations  in  INT8_LENGTH  generations to run
pop_size  in  INT8_LENGTH  individuals per generation
self_energy  in  ENERGY_LENGTH  cost per non-empty site
interact_energy  in  ENERGY_LENGTH  cost per equal non-empty adjacent pair
in_valid  in  1  individual offered
in_ready  out  1  block can accept an individual
ind_state_in  in  PARTICLE_LENGTH*LATTICE_LENGTH  individual; site 0 in LSBs
ind_mut_in  in  INT8_LENGTH  individual's mutation rate
fit_valid  out  1  one-cycle pulse, fit_out valid
fit_out  out  IND_FIT_LENGTH  fitness of last evaluated individual
min_fit_out  out  IND_FIT_LENGTH  running minimum fitness
best_ind_state  out  PARTICLE_LENGTH*LATTICE_LENGTH  individual with min fitness
best_ind_mut  out  INT8_LENGTH  its mutation rate
gen_count  out  INT8_LENGTH  completed generations
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; internal counters 0.
- FSM states:
  - IDLE: start → INIT; in_ready=0.
  - INIT: 1 cycle; latch config; min_fit_out=all-ones; best_*=0; gen_count=0; if num_generations==0 or pop_size==0 → DONE, else ACCEPT.
  - ACCEPT: in_ready=1; in_valid&&in_ready → capture state+mut, clear accumulator → EVAL.
  - EVAL: site i=0..L-1, one per cycle:
    - add self_energy if site i ≠ 0;
    - for i≥1, add interact_energy if site i == site i-1 and both ≠ 0;
    - after i=L-1 → UPDATE.
  - UPDATE: fit_out=acc; fit_valid pulse; if acc < min_fit_out (strict, first occurrence wins ties) update min_fit_out/best_ind_state/best_ind_mut; increment individual count; at pop_size: clear it, gen_count++; gen_count reaching num_generations → DONE, else ACCEPT.
  - DONE: done=1 for one cycle → IDLE. Outputs hold until next start.
- Latency: accept at cycle t → fit_valid at t+LATTICE_LENGTH+1. Throughput: one individual per LATTICE_LENGTH+2 cycles.
- Accumulator saturates at 2^IND_FIT_LENGTH−1; no wrap.
- start outside IDLE ignored. Config inputs sampled only in INIT. in_valid outside ACCEPT ignored (no capture).
- Zero-config run: done 2 cycles after start; min_fit_out all-ones, best_* = 0, gen_count = 0.

Optional Feature:
EV_PERIODIC_BOUNDARY_EN: defined → lattice is a ring; the extra pair (site L-1, site 0) is checked in the last EVAL cycle (same latency). Undefined → open chain, L-1 pairs only.

Test Plan:
- Reset mid-EVAL: assert rst_n=0 → all outputs 0, in_ready=0; new start runs normally.
- Defaults, self=3, interact=2, gen=1, pop=1, state 22'h155555 (all type 1) → fit_out=53 (55 with macro), fit_valid 12 cycles after accept, done one cycle after fit_valid.
- Alternating type 1/2 (22'h199999), self=3, interact=2 → fit_out=33 (35 with macro, sites 10 and 0 both type 1).
- gen=2, pop=3, fitnesses 40,20,20,30,50,25 with mut 1..6 → min_fit_out=20, best_ind_mut=2 (tie keeps first), gen_count=2, exactly 6 fit_valid pulses and one done.
- IND_FIT_LENGTH=6, self=15, interact=15, all type 1 → fit_out=63 (saturated).
- pop_size=0 → done two cycles after start, in_ready never high, min_fit_out=all-ones; start pulsed during EVAL is ignored.
